// File: rtl/cnn_layer_mem.sv
// Shared CNN image/weight/activation store with a per-layer region table.
// A sweep FSM zeroes the array after reset while the host is held off.
module cnn_layer_mem #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int DEPTH      = 375000,
  parameter int NUM_LAYERS = 5,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  input  logic                  cfg_we,
  input  logic [LW-1:0]         cfg_layer,
  input  logic [ADDR_W-1:0]     cfg_start,
  input  logic [ADDR_W-1:0]     cfg_end,
  input  logic                  eng_rd,
  input  logic [LW-1:0]         eng_layer,
  input  logic [ADDR_W-1:0]     eng_offset,
  output logic [DATA_W-1:0]     eng_rdata,
  output logic                  eng_rvalid,
  output logic                  eng_oob,
  output logic [NUM_LAYERS-1:0] present,
  output logic                  clear_busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [ADDR_W-1:0]     r_clr_cnt;
  logic [ADDR_W-1:0]     r_start [NUM_LAYERS];
  logic [ADDR_W-1:0]     r_end   [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_present;

  logic              w_clr;
  logic              w_idle;
  logic              w_hwr;
  logic              w_hrd;
  logic              w_hin;
  logic              w_cfg;
  logic              w_elay_ok;
  logic [ADDR_W-1:0] w_estart;
  logic [ADDR_W-1:0] w_eend;
  logic              w_epres;
  logic [ADDR_W:0]   w_phys;
  logic              w_eacc;
  logic              w_mwe;
  logic [ADDR_W-1:0] w_maddr;
  logic [DATA_W-1:0] w_mdata;

  assign w_clr  = (r_state == CLEAR) && !reset;
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_hwr  = w_idle && chipselect && write;
  assign w_hrd  = w_idle && chipselect && read && !write;
  assign w_hin  = {1'b0, address} < DEPTH_X;
  assign w_cfg  = w_idle && cfg_we
               && (32'(cfg_layer) < NUM_LAYERS);

  assign w_elay_ok = 32'(eng_layer) < NUM_LAYERS;
  assign w_estart  = w_elay_ok ? r_start[eng_layer] : '0;
  assign w_eend    = w_elay_ok ? r_end[eng_layer] : '0;
  assign w_epres   = w_elay_ok && r_present[eng_layer];
  // Sum is one bit wider so a large offset cannot wrap back into range.
  assign w_phys = {1'b0, w_estart} + {1'b0, eng_offset};
  assign w_eacc = w_idle && w_epres
               && (w_phys <= {1'b0, w_eend});

  assign w_mwe   = w_clr || (w_hwr && w_hin);
  assign w_maddr = w_clr ? r_clr_cnt : address;
  assign w_mdata = w_clr ? '0 : writedata;

  assign waitrequest = reset || (r_state == CLEAR);
  assign clear_busy  = waitrequest;
  assign present     = r_present;

  always_ff @(posedge clk) begin
    if (w_mwe) r_mem[w_maddr] <= w_mdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= w_hrd;
      if (w_hrd) readdata <= w_hin ? r_mem[address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eng_rdata  <= '0;
      eng_rvalid <= 1'b0;
      eng_oob    <= 1'b0;
    end else begin
      eng_rvalid <= eng_rd;
      if (eng_rd) begin
        eng_oob   <= !w_eacc;
        eng_rdata <= w_eacc ? r_mem[w_phys[ADDR_W-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_present <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        r_start[l] <= '0;
        r_end[l]   <= '0;
      end
    end else begin
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST) r_state <= IDLE;
      end
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (w_cfg && cfg_layer == LW'(l)) begin
          r_start[l]   <= cfg_start;
          r_end[l]     <= cfg_end;
          r_present[l] <= 1'b0;
        end else if (w_hwr && address == r_end[l]
                     && r_start[l] <= r_end[l]
                     && {1'b0, r_end[l]} < DEPTH_X) begin
          r_present[l] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_mem.sv
// Directed and randomized checks of cnn_layer_mem against a
// word-array reference model of its region/bounds rules.
module tb_cnn_layer_mem;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 16;
  localparam int NL = 5;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_layer = '0;
  logic [AW-1:0] cfg_start = '0;
  logic [AW-1:0] cfg_end = '0;
  logic          eng_rd = 1'b0;
  logic [LW-1:0] eng_layer = '0;
  logic [AW-1:0] eng_offset = '0;
  logic [DW-1:0] eng_rdata;
  logic          eng_rvalid;
  logic          eng_oob;
  logic [NL-1:0] present;
  logic          clear_busy;

  int tests = 0;
  int fails = 0;

  int mm [DEPTH];
  int ms [NL];
  int me [NL];
  logic [NL-1:0] mp;
  int busy;
  int e_rd, e_rdv, e_erd, e_erv, e_oob;

  cnn_layer_mem #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_LAYERS(NL)
  ) dut (
    .clk(clk), .reset(reset),
    .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_start(cfg_start), .cfg_end(cfg_end),
    .eng_rd(eng_rd), .eng_layer(eng_layer),
    .eng_offset(eng_offset), .eng_rdata(eng_rdata),
    .eng_rvalid(eng_rvalid), .eng_oob(eng_oob),
    .present(present), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    int p;
    bit acc;
    if (reset) begin
      e_rd = 0; e_rdv = 0; e_erd = 0; e_erv = 0; e_oob = 0;
      mp = '0;
      for (int l = 0; l < NL; l++) begin ms[l] = 0; me[l] = 0; end
      for (int a = 0; a < DEPTH; a++) mm[a] = 0;
      busy = DEPTH;
    end else if (busy > 0) begin
      busy--;
      e_rdv = 0;
      e_erv = int'(eng_rd);
      if (eng_rd) begin e_oob = 1; e_erd = 0; end
    end else begin
      e_erv = int'(eng_rd);
      if (eng_rd) begin
        acc = 0;
        p = 0;
        if (int'(eng_layer) < NL) begin
          p = ms[eng_layer] + int'(eng_offset);
          acc = mp[eng_layer] && (p <= me[eng_layer]);
        end
        e_oob = acc ? 0 : 1;
        e_erd = acc ? mm[p] : 0;
      end
      e_rdv = int'(chipselect && read && !write);
      if (e_rdv == 1)
        e_rd = (int'(address) < DEPTH) ? mm[address] : 0;
      if (chipselect && write) begin
        if (int'(address) < DEPTH) mm[address] = int'(writedata);
        for (int l = 0; l < NL; l++)
          if (int'(address) == me[l] && ms[l] <= me[l] && me[l] < DEPTH)
            mp[l] = 1'b1;
      end
      if (cfg_we && int'(cfg_layer) < NL) begin
        ms[cfg_layer] = int'(cfg_start);
        me[cfg_layer] = int'(cfg_end);
        mp[cfg_layer] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("waitrequest", 32'(waitrequest), 32'(reset || busy > 0));
    chk("clear_busy", 32'(clear_busy), 32'(reset || busy > 0));
    chk("readdatavalid", 32'(readdatavalid), 32'(e_rdv));
    chk("readdata", 32'(readdata), 32'(e_rd));
    chk("eng_rvalid", 32'(eng_rvalid), 32'(e_erv));
    chk("eng_rdata", 32'(eng_rdata), 32'(e_erd));
    chk("eng_oob", 32'(eng_oob), 32'(e_oob));
    chk("present", 32'(present), 32'(mp));
  endtask

  task automatic quiet();
    chipselect = 0; write = 0; read = 0;
    cfg_we = 0; eng_rd = 0;
  endtask

  task automatic host_wr(input int a, input int d);
    chipselect = 1; write = 1; read = 0;
    address = AW'(a); writedata = DW'(d);
    tick(); quiet();
  endtask

  task automatic host_rd(input int a);
    chipselect = 1; read = 1; write = 0; address = AW'(a);
    tick(); quiet();
  endtask

  task automatic eng(input int l, input int o);
    eng_rd = 1; eng_layer = LW'(l); eng_offset = AW'(o);
    tick(); quiet();
  endtask

  task automatic cfg(input int l, input int s, input int e);
    cfg_we = 1; cfg_layer = LW'(l);
    cfg_start = AW'(s); cfg_end = AW'(e);
    tick(); quiet();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (waitrequest === 1'b1 && n < 40) begin tick(); n++; end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    // T1: reset and full clear sweep
    tick(); tick();
    chk("rst_present", 32'(present), 32'd0);
    chk("rst_rdv", 32'(readdatavalid), 32'd0);
    reset = 0;
    wait_clear("clear_len");
    host_rd(5);
    chk("t1_rdv", 32'(readdatavalid), 32'd1);
    chk("t1_rd", 32'(readdata), 32'd0);
    tick();
    chk("t1_rdv_pulse", 32'(readdatavalid), 32'd0);

    // T2: load layer 1 and read through the engine
    cfg(1, 4, 7);
    for (int i = 0; i < 3; i++) host_wr(4 + i, 'hA1 + i);
    chk("t2_pres_early", 32'(present[1]), 32'd0);
    host_wr(7, 'hA4);
    chk("t2_pres", 32'(present[1]), 32'd1);
    eng(1, 2);
    chk("t2_edata", 32'(eng_rdata), 32'hA3);
    chk("t2_eoob", 32'(eng_oob), 32'd0);

    // T3: out-of-bounds and unloaded accesses
    eng(1, 4);
    chk("t3_oob", 32'(eng_oob), 32'd1);
    chk("t3_odata", 32'(eng_rdata), 32'd0);
    eng(0, 0);
    chk("t3_unl", 32'(eng_oob), 32'd1);
    host_wr(16, 'h77);
    host_rd(16);
    chk("t3_hi_rd", 32'(readdata), 32'd0);

    // T4: cfg beats a same-cycle completing write
    cfg_we = 1; cfg_layer = 1; cfg_start = 4; cfg_end = 7;
    host_wr(7, 'hA4);
    chk("t4_pres", 32'(present[1]), 32'd0);
    host_wr(7, 'hA4);
    chipselect = 1; write = 1; read = 1;
    address = 5; writedata = 'h66;
    tick(); quiet();
    chk("t4_wr_rd", 32'(readdatavalid), 32'd0);

    // T5: engine read-during-write returns old data
    eng_rd = 1; eng_layer = 1; eng_offset = 0;
    host_wr(4, 'h55);
    chk("t5_old", 32'(eng_rdata), 32'hA1);
    eng_rd = 1; eng_layer = 1; eng_offset = 0;
    host_rd(4);
    chk("t5_new_e", 32'(eng_rdata), 32'h55);
    chk("t5_new_h", 32'(readdata), 32'h55);

    // T6: reset mid-clear and after load
    reset = 1; tick(); reset = 0;
    repeat (8) tick();
    eng(1, 0);
    chk("t6_clr_oob", 32'(eng_oob), 32'd1);
    reset = 1; tick(); reset = 0;
    wait_clear("t6_clear_len");
    chk("t6_pres", 32'(present), 32'd0);
    host_rd(4);
    chk("t6_rd", 32'(readdata), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write = ($urandom_range(0, 1) == 1);
      read = ($urandom_range(0, 2) != 0);
      address = AW'($urandom_range(0, 19));
      writedata = DW'($urandom);
      cfg_we = ($urandom_range(0, 11) == 0);
      cfg_layer = LW'($urandom_range(0, 6));
      cfg_start = AW'($urandom_range(0, 15));
      cfg_end = AW'($urandom_range(0, 18));
      eng_rd = ($urandom_range(0, 1) == 1);
      eng_layer = LW'($urandom_range(0, 6));
      eng_offset = AW'($urandom_range(0, 9));
      tick();
    end
    reset = 0; quiet();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
